// File: rtl/mmm_nlp_pkg.sv
// Shared encodings and timing helpers for the x^5 mod p S-box stage.
package mmm_nlp_pkg;

   // Top-level control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RED  = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Multiplier pass: x*x, x2*x2, x4*x
   typedef enum logic [1:0] {
      PS_SQ1  = 2'd0,
      PS_SQ2  = 2'd1,
      PS_MULX = 2'd2
   } pass_e;

   localparam int unsigned MDW_DEF = 260;
   localparam int unsigned CNT_W   = $clog2(MDW_DEF);

   // Bit-index counter width for a given modulus width
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   // Accept edge to o_valid edge distance: 2 RED + 3 passes of w bits + DONE
   function automatic int unsigned lat(input int unsigned w);
      return 3 * w + 3;
   endfunction

endpackage

// File: rtl/modmul_step.sv
// One MSB-first interleaved modular multiply iteration: R' = (2R + b_bit*a) mod p.
module modmul_step #(
   parameter int unsigned MDW = 260
) (
   input  logic [MDW-1:0] r,
   input  logic [MDW-1:0] a,
   input  logic           b_bit,
   input  logic [MDW-1:0] p,
   output logic [MDW-1:0] r_next
);

   // Two bits of headroom so 2R and R1+a never overflow while R, a < p
   localparam int unsigned AW = MDW + 2;

   logic [AW-1:0] p_e;
   logic [AW-1:0] dbl;
   logic [AW-1:0] r1;
   logic [AW-1:0] r2;

   // Double, conditionally subtract, add partial product, conditionally subtract
   always_comb begin
      p_e    = AW'(p);
      dbl    = AW'(r) << 1;
      r1     = (dbl >= p_e) ? (dbl - p_e) : dbl;
      r2     = r1 + (b_bit ? AW'(a) : '0);
      r_next = MDW'((r2 >= p_e) ? (r2 - p_e) : r2);
   end

endmodule

// File: rtl/sbox_pow5.sv
// S-box stage: y = x^5 mod p via three bit-serial modular multiplies.
module sbox_pow5
   import mmm_nlp_pkg::*;
#(
   parameter int unsigned IDW = 260,
   parameter int unsigned ODW = 260,
   parameter int unsigned MDW = 260
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_valid,
   input  logic [IDW-1:0] i_x,
   input  logic [MDW-1:0] i_p,
   output logic           o_busy,
   output logic [ODW-1:0] o_y,
   output logic           o_valid
);

   localparam int unsigned    CW      = cnt_width(MDW);
   localparam logic [CW-1:0]  CNT_TOP = CW'(MDW - 1);

   state_e          state_q;
   state_e          state_d;
   pass_e           pass_q;
   logic [CW-1:0]   cnt_q;
   logic [MDW-1:0]  x_q;
   logic [MDW-1:0]  p_q;
   logic [MDW-1:0]  x2_q;
   logic [MDW-1:0]  x4_q;
   logic [MDW-1:0]  acc_q;

   logic            accept_c;
   logic            red_c;
   logic            mul_c;
   logic            done_c;
   logic            cnt_zero_c;
   logic [MDW-1:0]  op_a_c;
   logic [MDW-1:0]  op_b_c;
   logic [MDW-1:0]  acc_next_c;

   assign cnt_zero_c = (cnt_q == '0);

   // State register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_valid) state_d = ST_RED;
         ST_RED:  if (cnt_zero_c) state_d = ST_MUL;
         ST_MUL:  if (cnt_zero_c && (pass_q == PS_MULX)) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State decode into datapath strobes
   always_comb begin
      accept_c = 1'b0;
      red_c    = 1'b0;
      mul_c    = 1'b0;
      done_c   = 1'b0;
      case (state_q)
         ST_IDLE: accept_c = i_valid;
         ST_RED:  red_c    = 1'b1;
         ST_MUL:  mul_c    = 1'b1;
         ST_DONE: done_c   = 1'b1;
         default: ;
      endcase
   end

   // Multiplier operand selection per pass
   always_comb begin
      op_a_c = x_q;
      op_b_c = x_q;
      case (pass_q)
         PS_SQ1:  begin op_a_c = x_q;  op_b_c = x_q;  end
         PS_SQ2:  begin op_a_c = x2_q; op_b_c = x2_q; end
         PS_MULX: begin op_a_c = x4_q; op_b_c = x_q;  end
         default: ;
      endcase
   end

   modmul_step #(.MDW(MDW)) u_step (
      .r      (acc_q),
      .a      (op_a_c),
      .b_bit  (op_b_c[cnt_q]),
      .p      (p_q),
      .r_next (acc_next_c)
   );

   // Operand latch, input reduction, pass sequencing and result register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pass_q  <= PS_SQ1;
         cnt_q   <= '0;
         x_q     <= '0;
         p_q     <= '0;
         x2_q    <= '0;
         x4_q    <= '0;
         acc_q   <= '0;
         o_busy  <= 1'b0;
         o_y     <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;

         if (accept_c) begin
            x_q    <= MDW'(i_x);
            p_q    <= i_p;
            cnt_q  <= CW'(1);
            o_busy <= 1'b1;
         end

         // x < 3p, so two conditional subtracts leave x < p
         if (red_c) begin
            if (x_q >= p_q) x_q <= x_q - p_q;
            if (cnt_zero_c) begin
               cnt_q  <= CNT_TOP;
               pass_q <= PS_SQ1;
               acc_q  <= '0;
            end else begin
               cnt_q  <= cnt_q - CW'(1);
            end
         end

         if (mul_c) begin
            acc_q <= acc_next_c;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_zero_c) begin
               cnt_q <= CNT_TOP;
               case (pass_q)
                  PS_SQ1: begin
                     x2_q   <= acc_next_c;
                     acc_q  <= '0;
                     pass_q <= PS_SQ2;
                  end
                  PS_SQ2: begin
                     x4_q   <= acc_next_c;
                     acc_q  <= '0;
                     pass_q <= PS_MULX;
                  end
                  default: ;
               endcase
            end
         end

         if (done_c) begin
            o_y     <= ODW'(acc_q);
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sbox_pow5.sv
// Self-checking bench for sbox_pow5 at 8-bit and 260-bit modulus widths.
module tb_sbox_pow5;
   import mmm_nlp_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   logic         v8;
   logic [7:0]   x8;
   logic [7:0]   p8;
   logic         busy8;
   logic [7:0]   y8;
   logic         ov8;

   logic         v260;
   logic [259:0] x260;
   logic [259:0] p260;
   logic         busy260;
   logic [259:0] y260;
   logic         ov260;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sbox_pow5 #(.IDW(8), .ODW(8), .MDW(8)) u_dut8 (
      .i_clk   (clk),
      .i_rstn  (rst_n),
      .i_valid (v8),
      .i_x     (x8),
      .i_p     (p8),
      .o_busy  (busy8),
      .o_y     (y8),
      .o_valid (ov8)
   );

   sbox_pow5 #(.IDW(260), .ODW(260), .MDW(260)) u_dut260 (
      .i_clk   (clk),
      .i_rstn  (rst_n),
      .i_valid (v260),
      .i_x     (x260),
      .i_p     (p260),
      .o_busy  (busy260),
      .o_y     (y260),
      .o_valid (ov260)
   );

   task automatic check(input string tag, input logic [259:0] got, input logic [259:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain wide modular arithmetic
   function automatic logic [259:0] ref_pow5(input logic [259:0] x, input logic [259:0] p);
      logic [527:0] pm, xm, r2, r4, r5;
      pm = 528'(p);
      xm = 528'(x) % pm;
      r2 = (xm * xm) % pm;
      r4 = (r2 * r2) % pm;
      r5 = (r4 * xm) % pm;
      return 260'(r5);
   endfunction

   function automatic logic get_busy(input bit wide);
      return wide ? busy260 : busy8;
   endfunction

   function automatic logic get_ov(input bit wide);
      return wide ? ov260 : ov8;
   endfunction

   function automatic logic [259:0] get_y(input bit wide);
      return wide ? y260 : 260'(y8);
   endfunction

   // Present one operand; returns #1 after the accept edge with inputs scrambled
   task automatic start_op(input bit wide, input logic [259:0] x, input logic [259:0] p);
      @(negedge clk);
      if (wide) begin v260 = 1'b1; x260 = x; p260 = p; end
      else      begin v8 = 1'b1; x8 = x[7:0]; p8 = p[7:0]; end
      @(posedge clk);
      #1;
      v8   = 1'b0;
      v260 = 1'b0;
      x8   = 8'($urandom);
      p8   = 8'($urandom);
      x260 = {8{32'($urandom)}};
      p260 = {8{32'($urandom)}};
   endtask

   task automatic wait_done(input bit wide, input int budget, output int cyc, output logic [259:0] y);
      cyc = -1;
      y   = '0;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (get_ov(wide)) begin
            cyc = i;
            y   = get_y(wide);
            break;
         end
      end
   endtask

   task automatic run_op(input bit wide, input logic [259:0] x, input logic [259:0] p, input string tag);
      int           w;
      int           cyc;
      logic [259:0] y;
      logic [259:0] exp;
      w   = wide ? 260 : 8;
      exp = ref_pow5(x, p);
      start_op(wide, x, p);
      check({tag, " busy_acc"}, 260'(get_busy(wide)), 260'(1));
      wait_done(wide, int'(lat(w)) + 20, cyc, y);
      check({tag, " y"}, y, exp);
      check({tag, " lat"}, 260'(cyc), 260'(lat(w)));
      check({tag, " busy_done"}, 260'(get_busy(wide)), 260'(0));
      @(posedge clk);
      #1;
      check({tag, " pulse"}, 260'(get_ov(wide)), 260'(0));
      check({tag, " hold"}, get_y(wide), exp);
   endtask

   initial begin
      logic [259:0] rp;
      logic [259:0] rx;
      int           cyc;
      int           pulses;
      logic [259:0] y;

      rst_n = 1'b0;
      v8 = 1'b0;   x8 = '0;   p8 = '0;
      v260 = 1'b0; x260 = '0; p260 = '0;
      #1;
      check("rst busy8",   260'(busy8),   260'(0));
      check("rst ov8",     260'(ov8),     260'(0));
      check("rst y8",      260'(y8),      260'(0));
      check("rst busy260", 260'(busy260), 260'(0));
      check("rst ov260",   260'(ov260),   260'(0));
      check("rst y260",    y260,          260'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed 8-bit cases
      run_op(1'b0, 260'(3),   260'(13),  "p13_x3");
      check("p13_x3 abs", get_y(1'b0), 260'(9));
      run_op(1'b0, 260'(38),  260'(13),  "p13_x38");
      check("p13_x38 abs", get_y(1'b0), 260'(12));
      run_op(1'b0, 260'(0),   260'(128), "p128_x0");
      check("p128_x0 abs", get_y(1'b0), 260'(0));
      run_op(1'b0, 260'(2),   260'(128), "p128_x2");
      check("p128_x2 abs", get_y(1'b0), 260'(32));
      run_op(1'b0, 260'(127), 260'(128), "p128_x127");
      check("p128_x127 abs", get_y(1'b0), 260'(127));

      // Directed 260-bit cases
      rp = '0; rp[259] = 1'b1;
      run_op(1'b1, 260'(3), rp, "w_x3");
      check("w_x3 abs", get_y(1'b1), 260'(243));
      rx = '0; rx[200] = 1'b1;
      run_op(1'b1, rx, rp, "w_x2p200");
      check("w_x2p200 abs", get_y(1'b1), 260'(0));

      // Random 8-bit operands over the full 0 <= x < 3p range
      for (int k = 0; k < 30; k++) begin
         int unsigned pp, xmax;
         pp   = $urandom_range(255, 2);
         xmax = (3 * pp - 1 > 255) ? 255 : 3 * pp - 1;
         run_op(1'b0, 260'($urandom_range(xmax, 0)), 260'(pp), "rnd8");
      end

      // Random 260-bit operands
      for (int k = 0; k < 3; k++) begin
         rp = '0;
         rx = '0;
         for (int j = 0; j < 9; j++) begin
            rp = {rp[227:0], 32'($urandom)};
            rx = {rx[227:0], 32'($urandom)};
         end
         if (rp < 260'(2)) rp = rp + 260'(2);
         while (528'(rx) >= 528'(3) * 528'(rp)) rx = rx >> 1;
         run_op(1'b1, rx, rp, "rnd260");
      end

      // Second i_valid while busy is ignored
      start_op(1'b0, 260'(3), 260'(13));
      repeat (4) @(posedge clk);
      @(negedge clk);
      v8 = 1'b1; x8 = 8'd5; p8 = 8'd13;
      @(posedge clk);
      #1;
      v8 = 1'b0;
      wait_done(1'b0, 60, cyc, y);
      check("busy_ign y", y, 260'(9));
      check("busy_ign lat", 260'(cyc), 260'(lat(8) - 5));
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ov8) pulses++;
      end
      check("busy_ign extra", 260'(pulses), 260'(0));
      run_op(1'b0, 260'(5), 260'(13), "p13_x5");

      // Reset mid-multiply discards the operation
      start_op(1'b0, 260'(3), 260'(13));
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst busy", 260'(busy8), 260'(0));
      check("midrst y",    260'(y8),    260'(0));
      check("midrst ov",   260'(ov8),   260'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ov8) pulses++;
      end
      check("midrst nopulse", 260'(pulses), 260'(0));
      run_op(1'b0, 260'(3), 260'(13), "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
